// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
// Edge-mode encoding, FSM states and gate-counter sizing.
package freq_meter_pkg;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_BOTH = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  function automatic int gate_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Measurement bus: control and raw input in, published result out.
// The meter itself connects through the slave modport.
interface freq_meter_if #(
  parameter int COUNT_W = 16
);

  logic               en;
  logic               edge_mode;
  logic               sig_in;
  logic [COUNT_W-1:0] hz;
  logic               hz_valid;
  logic               hz_ovf;

  modport master (
    output en, edge_mode, sig_in,
    input  hz, hz_valid, hz_ovf
  );

  modport slave (
    input  en, edge_mode, sig_in,
    output hz, hz_valid, hz_ovf
  );

endinterface

// File: rtl/freq_meter_glitch_filter.sv
// Synchroniser plus stability filter for an asynchronous input.
// rise/fall flag the cycle in which the filtered level flips.
module glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int FW =
    (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [FW-1:0] STAB_LAST =
    FW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          stab_q, stab_d;
  logic                   lvl_q, lvl_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    stab_d = '0;
    lvl_d  = lvl_q;
    // Any cycle back at equality drops stab_d to zero.
    if (synced != lvl_q) begin
      if (stab_q == STAB_LAST) begin
        lvl_d = synced;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      stab_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      stab_q <= stab_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = lvl_d & ~lvl_q;
  assign fall = ~lvl_d & lvl_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts filtered edges per gate window
// and publishes the count with a valid strobe and overflow flag.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES   = 100_000_000,
  parameter int COUNT_W       = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  freq_meter_if.slave  bus
);

  localparam int GW = gate_w(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [GW-1:0]      gate_q, gate_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic               sat_q, sat_d, sat_nx;
  logic [COUNT_W-1:0] hz_q, hz_d;
  logic               hz_valid_q, hz_valid_d;
  logic               hz_ovf_q, hz_ovf_d;
  logic               rise, fall, hit, cnt_max;
  logic               unused_lvl;

  glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt (
    .clk   (clk),
    .rst   (rst),
    .sig_in(bus.sig_in),
    .lvl   (unused_lvl),
    .rise  (rise),
    .fall  (fall)
  );

  assign hit = rise |
    ((bus.edge_mode == EDGE_BOTH) & fall);
  assign cnt_max = &cnt_q;
  assign cnt_nx = (hit && !cnt_max) ?
    cnt_q + 1'b1 : cnt_q;
  assign sat_nx = sat_q | (hit & cnt_max);

  always_comb begin
    state_d    = state_q;
    gate_d     = '0;
    cnt_d      = '0;
    sat_d      = 1'b0;
    hz_d       = hz_q;
    hz_ovf_d   = hz_ovf_q;
    hz_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en) state_d = ARM;
      end
      ARM: begin
        state_d = MEAS;
      end
      MEAS: begin
        // Terminal edge closes the window; next starts at once.
        if (gate_q == GATE_LAST) begin
          hz_d       = cnt_nx;
          hz_ovf_d   = sat_nx;
          hz_valid_d = 1'b1;
          state_d    = bus.en ? MEAS : IDLE;
        end else if (!bus.en) begin
          state_d = IDLE;
        end else begin
          gate_d = gate_q + 1'b1;
          cnt_d  = cnt_nx;
          sat_d  = sat_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      hz_q       <= '0;
      hz_valid_q <= 1'b0;
      hz_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      hz_q       <= hz_d;
      hz_valid_q <= hz_valid_d;
      hz_ovf_q   <= hz_ovf_d;
    end
  end

  assign bus.hz       = hz_q;
  assign bus.hz_valid = hz_valid_q;
  assign bus.hz_ovf   = hz_ovf_q;

endmodule

// File: doc/freq_meter.md
# freq_meter

Parametrised gated frequency meter, the successor to the team's fixed one-second Hz counter. It synchronises and de-glitches an external digital signal such as the mic comparator output on a Pmod pin. It counts qualified edges over an internally generated gate window and publishes the count once per window with a valid strobe and an overflow flag. It sits between the Pmod input and the signal-handler / top-level decision logic and replaces the external one-second timer dependency.

## Interface
- `GATE_CYCLES`, default 100_000_000: clk cycles per measurement window (1 s at 100 MHz); must be ≥ 2.
- `COUNT_W`, default 16: width of the edge counter and the result.
- `SYNC_STAGES`, default 2: input synchroniser depth; must be ≥ 2.
- `FILTER_CYCLES`, default 4: consecutive stable cycles required to accept a level change; must be ≥ 1.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `en`, in, 1: measurement enable.
- `edge_mode`, in, 1: 0 counts rising edges only; 1 counts both edges.
- `sig_in`, in, 1: asynchronous input signal.
- `hz`, out, COUNT_W: edge count of the last completed window.
- `hz_valid`, out, 1: one-cycle pulse when `hz` updates.
- `hz_ovf`, out, 1: last completed window saturated; valid with `hz`.

## Operation
- Input path:
  - `sig_in` passes through a SYNC_STAGES flop chain, then the glitch filter.
  - The filtered level `lvl` (reset 0) takes the synced value only after it has differed from `lvl` for FILTER_CYCLES consecutive cycles.
  - Any return to equality clears the stability counter.
- Edge qualify: an edge is the cycle where `lvl` changes.
  - Mode 0 counts only 0→1.
  - Mode 1 counts both directions.
  - `edge_mode` is sampled every cycle; changing it mid-window is legal and affects only subsequent edges.
- FSM states:
  - IDLE: gate counter and edge counter held at 0. `hz` and `hz_ovf` hold their last values. Goes to ARM when `en`=1.
  - ARM: lasts exactly one cycle, clearing both counters. Goes to MEAS.
  - MEAS: the gate counter increments 0..GATE_CYCLES-1. Each qualified edge increments the edge counter. When the gate counter reaches GATE_CYCLES-1 it is the terminal cycle.
- Terminal cycle:
  - `hz` ← count including any edge in that same cycle.
  - `hz_ovf` ← saturation flag.
  - Pulse `hz_valid`.
  - Counters reset to 0, and the next window begins the following cycle with no gap. An edge on the terminal cycle belongs to the closing window only.
- Saturation: the edge counter stops at 2^COUNT_W−1 and sets an internal sat flag. The flag clears at window start.
- `en` deasserted in MEAS: go to IDLE next cycle. The partial window is discarded, with no `hz_valid` and no update. If `en` falls on the terminal cycle, that window still publishes.
- `rst` at any time: all state is cleared on the next edge. This includes the synchroniser, filter, `lvl`, FSM→IDLE and the counters. `rst` overrides `en`.

## Timing
- Reset values: `hz`=0, `hz_valid`=0, `hz_ovf`=0, FSM=IDLE, `lvl`=0.
- Latency from a `sig_in` transition to the counter increment is SYNC_STAGES + FILTER_CYCLES + 1 cycles, ±1 for asynchronous sampling.
- First `hz_valid` after `en` rises is 1 (ARM) + GATE_CYCLES cycles later. After that, `hz_valid` pulses every GATE_CYCLES cycles exactly.
- `hz` and `hz_ovf` are registered and stable between pulses.
- Input pulses shorter than FILTER_CYCLES cycles are never counted. The maximum countable rate is clk/(2·FILTER_CYCLES) per full period.

## Structure
- Package `freq_meter_pkg`:
  - Edge-mode constants `EDGE_RISE`=0 and `EDGE_BOTH`=1.
  - The FSM state enum (IDLE, ARM, MEAS).
  - A width helper for the gate counter: clog2(GATE_CYCLES).
- Sub-module `glitch_filter` contains the synchroniser, stability counter and `lvl` register. It is parametrised by SYNC_STAGES and FILTER_CYCLES and outputs `lvl`, `rise` and `fall`.
- The top level holds the FSM, gate counter, saturating edge counter and output registers.

## Test plan
All scenarios use GATE_CYCLES=100, COUNT_W=4, SYNC_STAGES=2, FILTER_CYCLES=2, edge_mode=0 unless stated.
- Square wave with a 10-cycle period, `en` held high: every `hz_valid` after the first full window gives `hz`=10, `hz_ovf`=0. Pulses are spaced exactly 100 cycles apart.
- Same wave with edge_mode=1: `hz`=15 with `hz_ovf`=1, since 20 edges saturate at 4 bits. With COUNT_W=8, `hz`=20 and `hz_ovf`=0.
- Single-cycle glitches on `sig_in` every 7 cycles: `hz`=0 every window.
- `en` dropped at gate count 50: no `hz_valid` occurs and `hz` keeps its previous value. Re-raising `en` gives the first pulse 101 cycles later.
- A rising edge timed to qualify on the terminal cycle: it is counted in the closing window, and the next window's count excludes it.
- `rst` asserted mid-window with `sig_in` high: after release, all outputs are 0. The still-high input produces one counted rising edge once it is filtered.
